// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte-masked writes commit at accept,
// the response (read word or post-write word) is presented LATENCY cycles later.
module dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready is high only in IDLE (and never while reset is asserted);
  // rsp_valid/rsp_rdata/rsp_err are held stable in RESP until rsp_ready.
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0]      mem_q [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             accept;
  logic             mem_we;
  logic [31:0]      merged;

  assign idx       = req_addr[IDX_W-1:0];
  assign in_range  = ({16'h0000, req_addr} < 32'(MEM_WORDS));
  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_we    = accept && (req_wstrb != 4'b0000) && in_range;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // For a read (wstrb==0) the merged word is simply the stored word.
  always_comb begin
    merged = mem_q[idx];
    for (int i = 0; i < 4; i++) begin
      if (req_wstrb[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= merged;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d = in_range ? merged : 32'h0;
          err_d  = !in_range;
          cnt_d  = 3'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = word_d;
            rsp_err_d   = err_d;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = word_q;
          rsp_err_d   = err_q;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      word_q      <= 32'h0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
